// File: rtl/taxi_axi_pkg.sv
// Shared AXI encodings: burst types and response codes.
// Used by the AXI4 <-> AXI-Lite adapters and their address generator.
package taxi_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/taxi_axi_if.sv
// AXI4 read-channel bundle (AR + R).
// Pure wiring: no latency, handshakes are carried by valid/ready.
interface taxi_axi_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 8,
    parameter int ARUSER_W = 1,
    parameter int RUSER_W  = 1
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic [ARUSER_W-1:0] aruser;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [RUSER_W-1:0]  ruser;
    logic                rvalid;
    logic                rready;

    modport rd_slv (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arqos, arregion, aruser, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, ruser, rvalid
    );

    modport rd_mst (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arqos, arregion, aruser, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, ruser, rvalid
    );
endinterface

// File: rtl/taxi_axil_if.sv
// AXI-Lite read-channel bundle (AR + R).
// Pure wiring: no latency, handshakes are carried by valid/ready.
interface taxi_axil_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport rd_mst (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport rd_slv (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/taxi_axi_burst_addr_gen.sv
// Next-beat address for an AXI burst (FIXED / INCR / WRAP, reserved treated as INCR).
// Latency: combinational. Backpressure: none, caller advances on its own handshake.
module taxi_axi_burst_addr_gen
    import taxi_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);
    localparam int SIZE_MAX = $clog2(DATA_W/8);

    logic [2:0]        size_e;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        // Beats wider than the bus are clamped to the bus width.
        size_e    = (size > 3'(SIZE_MAX)) ? 3'(SIZE_MAX) : size;
        incr      = ADDR_W'(1) << size_e;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size_e) - ADDR_W'(1);
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if (burst == BURST_WRAP) begin
            next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
        end else begin
            next_addr = (addr & ~(incr - ADDR_W'(1))) + incr;
        end
    end
endmodule

// File: rtl/taxi_axi_axil_adapter_rd.sv
// AXI4 -> AXI-Lite read bridge: bursts split into pipelined single-beat Lite reads.
// Latency: first Lite AR one cycle after the AXI AR handshake; R path is combinational.
// Backpressure: Lite ARs stall at MAX_OUTSTANDING in flight; R ready passes straight through.
module taxi_axi_axil_adapter_rd
    import taxi_axi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    taxi_axi_if.rd_slv  s_axi_rd,
    taxi_axil_if.rd_mst m_axil_rd
);
    localparam int DATA_W   = s_axi_rd.DATA_W;
    localparam int ADDR_W   = s_axi_rd.ADDR_W;
    localparam int ID_W     = s_axi_rd.ID_W;
    localparam int L_DATA_W = m_axil_rd.DATA_W;
    localparam int L_ADDR_W = m_axil_rd.ADDR_W;
    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

    if (DATA_W != L_DATA_W || ADDR_W != L_ADDR_W) begin : g_width_err
        $error("taxi_axi_axil_adapter_rd: AXI and AXI-Lite DATA_W/ADDR_W differ");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : g_out_err
        $error("taxi_axi_axil_adapter_rd: MAX_OUTSTANDING out of range 1..16");
    end

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   id_reg;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        len_reg;
    logic [2:0]        size_reg;
    logic [1:0]        burst_reg;
    logic [2:0]        prot_reg;
    logic [8:0]        ar_cnt;
    logic [8:0]        r_cnt;
    logic [OUT_W-1:0]  outstanding;

    logic s_ar_hs, l_ar_hs, r_hs, in_burst;

    assign in_burst = (state == ST_BURST);
    assign s_ar_hs  = s_axi_rd.arvalid && s_axi_rd.arready;
    assign l_ar_hs  = m_axil_rd.arvalid && m_axil_rd.arready;
    assign r_hs     = s_axi_rd.rvalid && s_axi_rd.rready;

    assign s_axi_rd.arready  = (state == ST_IDLE) && !rst;
    assign m_axil_rd.arvalid = in_burst && (ar_cnt != 9'd0) && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign m_axil_rd.araddr  = cur_addr;
    assign m_axil_rd.arprot  = prot_reg;

    // Lite responses come back in order, so the R path is a gated pass-through.
    assign s_axi_rd.rvalid = m_axil_rd.rvalid && in_burst;
    assign m_axil_rd.rready = s_axi_rd.rready && in_burst;
    assign s_axi_rd.rdata  = m_axil_rd.rdata;
    assign s_axi_rd.rresp  = m_axil_rd.rresp;
    assign s_axi_rd.rid    = id_reg;
    assign s_axi_rd.ruser  = '0;
    assign s_axi_rd.rlast  = (r_cnt == 9'd1);

    taxi_axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_addr_gen (
        .addr      (cur_addr),
        .len       (len_reg),
        .size      (size_reg),
        .burst     (burst_reg),
        .next_addr (next_addr)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (s_ar_hs) state_nxt = ST_BURST;
            ST_BURST: if (r_hs && s_axi_rd.rlast) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_reg      <= '0;
            cur_addr    <= '0;
            len_reg     <= '0;
            size_reg    <= '0;
            burst_reg   <= '0;
            prot_reg    <= '0;
            ar_cnt      <= '0;
            r_cnt       <= '0;
            outstanding <= '0;
        end else if (state == ST_IDLE) begin
            if (s_ar_hs) begin
                id_reg    <= s_axi_rd.arid;
                cur_addr  <= s_axi_rd.araddr;
                len_reg   <= s_axi_rd.arlen;
                size_reg  <= s_axi_rd.arsize;
                burst_reg <= s_axi_rd.arburst;
                prot_reg  <= s_axi_rd.arprot;
                ar_cnt    <= {1'b0, s_axi_rd.arlen} + 9'd1;
                r_cnt     <= {1'b0, s_axi_rd.arlen} + 9'd1;
            end
        end else begin
            if (l_ar_hs) begin
                ar_cnt   <= ar_cnt - 9'd1;
                cur_addr <= next_addr;
            end
            if (r_hs) begin
                r_cnt <= r_cnt - 9'd1;
            end
            if (l_ar_hs && !r_hs) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!l_ar_hs && r_hs) begin
                outstanding <= outstanding - OUT_W'(1);
            end
        end
    end
endmodule
